// File: rtl/gate_check_pkg.sv
// Shared constants for the gate truth-table checker: FSM state codes,
// settle-timer width and reference truth tables for common 2-input gates.
package gate_check_pkg;

  // Sweep controller states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  // Settle timer width: holds settle counts up to 15
  localparam int SETTLE_W = 4;

  // Reference truth tables, bit i = expected output for input vector i
  // (vector bit 1 = input a, bit 0 = input b)
  localparam logic [3:0] EXPECT_NOR2  = 4'b0001;
  localparam logic [3:0] EXPECT_OR2   = 4'b1110;
  localparam logic [3:0] EXPECT_AND2  = 4'b1000;
  localparam logic [3:0] EXPECT_NAND2 = 4'b0111;

endpackage

// File: rtl/settle_timer.sv
// Down-counter that measures how long a stimulus vector has been held.
// Loading sets it to SETTLE-1 so that 'expired' rises on the SETTLE-th
// cycle after the load edge; it then rests at zero until reloaded.
module settle_timer
  import gate_check_pkg::*;
#(
  parameter int SETTLE = 1
)(
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic expired
);

  localparam logic [SETTLE_W-1:0] RELOAD = SETTLE_W'(SETTLE - 1);

  logic [SETTLE_W-1:0] count;

  // Reload on request, otherwise count down to zero and stay there
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= RELOAD;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/gate_truth_checker.sv
// Exhaustive truth-table checker for a combinational gate. On start it walks
// every input vector, holds each for SETTLE cycles, samples the gate output
// for one cycle and compares it against the EXPECT table, accumulating a
// mismatch count and the index of the first failing vector.
module gate_truth_checker
  import gate_check_pkg::*;
#(
  parameter int                    N_IN   = 2,
  parameter logic [(1<<N_IN)-1:0]  EXPECT = EXPECT_NOR2,
  parameter int                    SETTLE = 1
)(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            dut_out,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail
);

  localparam logic [N_IN-1:0] IDX_LAST = '1;

  logic [1:0]      state;
  logic [N_IN-1:0] idx;
  logic            last_vec;
  logic            mismatch;
  logic [N_IN:0]   err_next;
  logic            accept;
  logic            timer_load;
  logic            timer_expired;

  assign accept     = (state == ST_IDLE) && start;
  assign last_vec   = (idx == IDX_LAST);
  assign mismatch   = (dut_out != EXPECT[idx]);
  assign err_next   = err_count + {{N_IN{1'b0}}, mismatch};
  // Every new vector (including the first) restarts the settle window
  assign timer_load = accept || ((state == ST_SAMPLE) && !last_vec);

  settle_timer #(
    .SETTLE (SETTLE)
  ) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .expired (timer_expired)
  );

  // Sweep sequencing: vector index and state transitions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_DRIVE;
            idx   <= '0;
          end
        end
        ST_DRIVE: begin
          if (timer_expired) state <= ST_SAMPLE;
        end
        ST_SAMPLE: begin
          // The last vector stays on stim after the sweep; idx never wraps
          if (last_vec) begin
            state <= ST_DONE;
          end else begin
            idx   <= idx + 1'b1;
            state <= ST_DRIVE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Result bookkeeping: cleared on an accepted start, updated on each sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (accept) begin
      err_count  <= '0;
      first_fail <= '0;
      pass       <= 1'b0;
    end else if (state == ST_SAMPLE) begin
      if (mismatch) begin
        err_count <= err_next;
        if (err_count == '0) first_fail <= idx;
      end
      // err_next already includes this final sample's verdict
      if (last_vec) pass <= (err_next == '0);
    end
  end

  assign stim = idx;
  assign busy = (state == ST_DRIVE) || (state == ST_SAMPLE);
  assign done = (state == ST_DONE);

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: two instances (2-input NOR, SETTLE=1 and
// 3-input NOR, SETTLE=3) each drive a bench-side gate defined by a truth
// table. Expected sweep results come from a reference model and are queued
// at start; a monitor pops them on every done pulse and also checks stim
// walk, sweep length, reset values and result holding while idle.
module tb_gate_truth_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       start_a, start_b;
  logic [3:0] tt_a;
  logic [7:0] tt_b;
  logic       dut_out_a, dut_out_b;
  logic [1:0] stim_a;
  logic [2:0] stim_b;
  logic       busy_a, busy_b, done_a, done_b, pass_a, pass_b;
  logic [2:0] err_a;
  logic [3:0] err_b;
  logic [1:0] ff_a;
  logic [2:0] ff_b;

  assign dut_out_a = tt_a[stim_a];
  assign dut_out_b = tt_b[stim_b];

  gate_truth_checker #(.N_IN(2), .EXPECT(4'b0001), .SETTLE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .dut_out(dut_out_a),
    .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_count(err_a), .first_fail(ff_a)
  );

  gate_truth_checker #(.N_IN(3), .EXPECT(8'b00000001), .SETTLE(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dut_out(dut_out_b),
    .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b),
    .err_count(err_b), .first_fail(ff_b)
  );

  typedef struct {
    int err;
    int ff;
    bit pass;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference: an N-input NOR outputs 1 only for the all-zero vector.
  function automatic exp_t model(int d, logic [7:0] tt);
    exp_t e;
    int   nvec;
    bit   want;
    nvec   = (d == 0) ? 4 : 8;
    e.err  = 0;
    e.ff   = 0;
    for (int i = 0; i < nvec; i++) begin
      want = (i == 0);
      if (tt[i] != want) begin
        if (e.err == 0) e.ff = i;
        e.err++;
      end
    end
    e.pass = (e.err == 0);
    return e;
  endfunction

  // Monitor / scoreboard
  int blen[2];
  int last_err[2];
  int last_ff[2];
  int last_stim[2];
  int last_pass[2];
  bit prev_busy[2];

  always @(negedge clk) begin
    int   st, er, ff, per, vecs;
    bit   bz, dn, ps;
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (d == 0) begin
        st = int'(stim_a); er = int'(err_a); ff = int'(ff_a);
        bz = busy_a; dn = done_a; ps = pass_a; per = 2; vecs = 4;
      end else begin
        st = int'(stim_b); er = int'(err_b); ff = int'(ff_b);
        bz = busy_b; dn = done_b; ps = pass_b; per = 4; vecs = 8;
      end
      if (!rst_n) begin
        check($sformatf("rst_stim%0d", d), st, 0);
        check($sformatf("rst_busy%0d", d), int'(bz), 0);
        check($sformatf("rst_done%0d", d), int'(dn), 0);
        check($sformatf("rst_pass%0d", d), int'(ps), 0);
        check($sformatf("rst_err%0d", d), er, 0);
        check($sformatf("rst_ff%0d", d), ff, 0);
        blen[d] = 0; last_err[d] = 0; last_ff[d] = 0;
        last_stim[d] = 0; last_pass[d] = 0;
      end else if (bz) begin
        check($sformatf("busy_stim%0d", d), st, blen[d] / per);
        check($sformatf("busy_pass%0d", d), int'(ps), 0);
        check($sformatf("busy_done%0d", d), int'(dn), 0);
        blen[d]++;
      end else if (dn) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL done_unexpected%0d: got done pulse, required none (t=%0t)", d, $time);
        end else begin
          e = sb.pop_front();
          check($sformatf("done_err%0d", d), er, e.err);
          check($sformatf("done_ff%0d", d), ff, e.ff);
          check($sformatf("done_pass%0d", d), int'(ps), int'(e.pass));
        end
        check($sformatf("sweep_len%0d", d), blen[d], per * vecs);
        check($sformatf("done_after_busy%0d", d), int'(prev_busy[d]), 1);
        check($sformatf("done_stim%0d", d), st, vecs - 1);
        blen[d] = 0; last_err[d] = er; last_ff[d] = ff;
        last_pass[d] = int'(ps); last_stim[d] = vecs - 1;
      end else begin
        check($sformatf("idle_err%0d", d), er, last_err[d]);
        check($sformatf("idle_ff%0d", d), ff, last_ff[d]);
        check($sformatf("idle_pass%0d", d), int'(ps), last_pass[d]);
        check($sformatf("idle_stim%0d", d), st, last_stim[d]);
      end
      prev_busy[d] = bz;
    end
  end

  task automatic wait_done(int d);
    bit seen = 1'b0;
    for (int n = 0; n < 400 && !seen; n++) begin
      @(negedge clk);
      seen = (d == 0) ? done_a : done_b;
    end
    if (!seen) begin
      tests++; fails++;
      $display("FAIL timeout%0d: no done within 400 cycles, required one", d);
    end
  endtask

  // Raise start for one cycle, queue the expected result, check busy rises
  task automatic start_sweep(int d, logic [7:0] tt);
    @(posedge clk); #1;
    if (d == 0) begin tt_a = tt[3:0]; start_a = 1'b1; end
    else        begin tt_b = tt;      start_b = 1'b1; end
    sb.push_back(model(d, tt));
    @(posedge clk); #1;
    start_a = 1'b0; start_b = 1'b0;
    @(negedge clk);
    check($sformatf("busy_after_start%0d", d), int'((d == 0) ? busy_a : busy_b), 1);
  endtask

  task automatic sweep(int d, logic [7:0] tt);
    start_sweep(d, tt);
    wait_done(d);
    repeat (3) @(posedge clk);
  endtask

  initial begin
    rst_n = 1'b1; start_a = 1'b0; start_b = 1'b0;
    tt_a = 4'b0001; tt_b = 8'h01;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Directed 2-input cases: correct NOR, OR, stuck-at-0, stuck-at-1
    sweep(0, 8'h01);
    sweep(0, 8'h0E);
    sweep(0, 8'h00);
    sweep(0, 8'h0F);

    // start pulsed again during vector 2 is ignored
    start_sweep(0, 8'h01);
    repeat (3) @(posedge clk);
    #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    wait_done(0);
    repeat (5) @(posedge clk);

    // Reset during vector 1 aborts the sweep without a done pulse
    start_sweep(0, 8'h0E);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    void'(sb.pop_back());
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    sweep(0, 8'h01);

    // start held high through DONE launches a second sweep from IDLE
    @(posedge clk); #1;
    tt_a = 4'b0001; start_a = 1'b1;
    sb.push_back(model(0, 8'h01));
    wait_done(0);
    sb.push_back(model(0, 8'h01));
    @(posedge clk); #1;
    @(posedge clk); #1 start_a = 1'b0;
    @(negedge clk);
    check("held_start_relaunch", int'(busy_a), 1);
    wait_done(0);
    repeat (3) @(posedge clk);

    // Random 2-input gates
    for (int k = 0; k < 8; k++) sweep(0, 8'($urandom_range(0, 15)));

    // 3-input NOR with SETTLE=3: correct gate, then random gates
    sweep(1, 8'h01);
    sweep(1, 8'hFE);
    for (int k = 0; k < 4; k++) sweep(1, 8'($urandom_range(0, 255)));

    repeat (5) @(posedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
